// File: rtl/gpu_result_uart_tx.sv
// Result-reporting UART transmitter: queues {exception, X, Y} results and sends
// each one as a 5-byte packet (header, X hi/lo, Y hi/lo), 8N1, LSB first.
`timescale 1ns/1ps
module gpu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iValid,
  input  logic [15:0] iX,
  input  logic [15:0] iY,
  input  logic        iException,
  output logic        oReady,
  output logic        oTx,
  output logic        oBusy,
  output logic        oOverflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [39:0]       shift_q, shift_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic [32:0] fifo_mem [FIFO_DEPTH];
  logic [32:0] head;
  logic [7:0]  cur_byte;
  logic        ready, push, pop, baud_tick, tx;

  assign ready     = (count_q < DEPTH_C);
  assign push      = iValid && ready;
  assign head      = fifo_mem[rd_ptr_q];
  assign cur_byte  = shift_q[39:32];
  assign baud_tick = (baud_q == BAUD_LAST);

  // Storage is not reset: clearing the count is enough to discard queued results.
  always_ff @(posedge iClock) begin
    if (push) fifo_mem[wr_ptr_q] <= {iException, iX, iY};
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx      = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = {7'b1010010, head};
          byte_d  = 3'd0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        tx = cur_byte[bit_q];
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          // Next byte follows the stop bit directly; only packets are separated.
          if (byte_q < 3'd4) begin
            byte_d  = byte_q + 1'b1;
            shift_d = {shift_q[31:0], 8'h00};
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 3'd0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (iValid && !ready) overflow_q <= 1'b1;
    end
  end

  // Line level decodes straight from registered state, so reset idles it at once.
  assign oTx       = tx;
  assign oReady    = ready;
  assign oBusy     = (state_q != S_IDLE) || (count_q != '0);
  assign oOverflow = overflow_q;

endmodule

// File: tb/tb_gpu_result_uart_tx.sv
// Directed bench for gpu_result_uart_tx: a fast instance (4 clocks/bit) for
// packet content and timing, plus a default-rate instance for baud timing.
`timescale 1ns/1ps
module tb_gpu_result_uart_tx;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int PKT_GAP  = 50 * CPB + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, exc = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        ready, tx, busy, ovf;
  logic        valid_s = 1'b0, exc_s = 1'b0;
  logic [15:0] x_s = '0, y_s = '0;
  logic        ready_s, tx_s, busy_s, ovf_s;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int hold_err = 0;
  int frame_err = 0;
  logic [7:0] rx_q [$];
  int         rx_cyc_q [$];

  gpu_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .iClock(clk), .iReset(rst_n), .iValid(valid), .iX(x), .iY(y),
    .iException(exc), .oReady(ready), .oTx(tx), .oBusy(busy), .oOverflow(ovf)
  );

  gpu_result_uart_tx dut_slow (
    .iClock(clk), .iReset(rst_n), .iValid(valid_s), .iX(x_s), .iY(y_s),
    .iException(exc_s), .oReady(ready_s), .oTx(tx_s), .oBusy(busy_s), .oOverflow(ovf_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver on the fast line: one byte per frame, every cycle of each bit checked.
  initial begin : monitor
    logic [9:0] bits;
    bit         abort;
    int         s;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        s = cyc;
        abort = 1'b0;
        bits = '0;
        for (int k = 0; k < BYTE_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            abort = 1'b1;
            break;
          end
          if (k % CPB == 0) bits[k/CPB] = tx;
          else if (tx !== bits[k/CPB]) hold_err++;
        end
        if (!abort) begin
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err++;
          rx_q.push_back(bits[8:1]);
          rx_cyc_q.push_back(s);
        end
      end
    end
  end

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int limit);
    int t0;
    t0 = cyc;
    while (rx_q.size() < n && (cyc - t0) < limit) @(negedge clk);
    check({tag, "_rx_count"}, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t0;
    t0 = cyc;
    while (busy && (cyc - t0) < limit) @(negedge clk);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_pkt(input string tag, input int idx, input logic [39:0] exp, input int start);
    for (int b = 0; b < 5; b++) begin
      check($sformatf("%s_byte%0d", tag, b), rx_q[idx+b], exp[39-8*b -: 8]);
      check($sformatf("%s_time%0d", tag, b), rx_cyc_q[idx+b], start + b * BYTE_CYC);
    end
  endtask

  task automatic check_line(input string tag);
    check({tag, "_hold"}, hold_err, 0);
    check({tag, "_frame"}, frame_err, 0);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc_q.delete();
    hold_err = 0;
    frame_err = 0;
  endtask

  task automatic push(input logic [15:0] px, input logic [15:0] py, input logic pe);
    valid = 1'b1;
    x = px;
    y = py;
    exc = pe;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  initial begin
    int p, w, lows;
    logic [15:0] px, py;
    logic        pe;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_tx_slow", tx_s, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    // Single packet, latency and busy timing
    p = cyc;
    push(16'h1234, 16'hABCD, 1'b0);
    check("t1_tx_pop_cycle", tx, 1'b1);
    check("t1_ready", ready, 1'b1);
    check("t1_busy", busy, 1'b1);
    @(negedge clk);
    check("t1_tx_start", tx, 1'b0);
    wait_cycle(p + 201);
    check("t1_busy_last_stop", busy, 1'b1);
    wait_cycle(p + 202);
    check("t1_busy_fall", busy, 1'b0);
    wait_cycle(p + 230);
    check("t1_tx_idle", tx, 1'b1);
    check("t1_rx_count", rx_q.size(), 5);
    check_pkt("t1", 0, 40'hA4_1234_ABCD, p + 2);
    check_line("t1");
    clear_rx();

    // Exception header and all-ones / high-bit patterns
    p = cyc;
    push(16'hFFFF, 16'h8000, 1'b1);
    wait_bytes("t2", 5, 400);
    check_pkt("t2", 0, 40'hA5_FFFF_8000, p + 2);
    check_line("t2");
    wait_idle("t2", 50);
    clear_rx();

    // Six back-to-back offers into a depth-4 FIFO
    p = cyc;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) check("t3_ready_c4", ready, 1'b1);
      if (i == 5) begin
        check("t3_ready_c5", ready, 1'b0);
        check("t3_ovf_c5", ovf, 1'b0);
      end
      valid = 1'b1;
      x = 16'(i + 1);
      y = 16'(16'h0100 + i + 1);
      exc = 1'b0;
      @(negedge clk);
    end
    valid = 1'b0;
    check("t3_ovf_c6", ovf, 1'b1);
    wait_bytes("t3", 25, 1400);
    repeat (300) @(negedge clk);
    check("t3_no_sixth", rx_q.size(), 25);
    for (int k = 0; k < 5; k++)
      check_pkt($sformatf("t3_p%0d", k), 5 * k, {8'hA4, 16'(k + 1), 16'(16'h0100 + k + 1)},
                p + 2 + k * PKT_GAP);
    check("t3_ovf_sticky", ovf, 1'b1);
    check_line("t3");
    wait_idle("t3", 50);
    clear_rx();

    // Reset in the middle of byte 2 with two results still queued
    p = cyc;
    push(16'h1100, 16'h0001, 1'b0);
    push(16'h2200, 16'h0002, 1'b0);
    push(16'h3300, 16'h0003, 1'b0);
    wait_cycle(p + 90);
    check("t4_tx_low_before", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t4_tx_async", tx, 1'b1);
    check("t4_busy_async", busy, 1'b0);
    check("t4_ovf_async", ovf, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_rx();
    @(negedge clk);
    check("t4_busy", busy, 1'b0);
    check("t4_ready", ready, 1'b1);
    check("t4_ovf", ovf, 1'b0);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t4_line_quiet", lows, 0);
    check("t4_rx_none", rx_q.size(), 0);

    // Push coincident with a pop at count 2, then fill and drain from full
    p = cyc;
    push(16'h0A01, 16'h5000, 1'b0);
    push(16'h0A02, 16'h5001, 1'b1);
    push(16'h0A03, 16'h5002, 1'b0);
    wait_cycle(p + 202);
    valid = 1'b1; x = 16'h0A04; y = 16'h5003; exc = 1'b1;
    @(negedge clk);
    check("t6_ready_after_pushpop", ready, 1'b1);
    x = 16'h0A05; y = 16'h5004; exc = 1'b0;
    @(negedge clk);
    check("t6_ready_count3", ready, 1'b1);
    x = 16'h0A06; y = 16'h5005; exc = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("t6_ready_full", ready, 1'b0);
    wait_cycle(p + 403);
    check("t6_ready_pop_cycle", ready, 1'b0);
    wait_cycle(p + 404);
    check("t6_ready_reassert", ready, 1'b1);
    wait_bytes("t6", 30, 1500);
    for (int k = 0; k < 6; k++) begin
      px = 16'(16'h0A01 + k);
      py = 16'(16'h5000 + k);
      pe = (k % 2) == 1;
      check_pkt($sformatf("t6_p%0d", k), 5 * k, {7'b1010010, pe, px, py}, p + 2 + k * PKT_GAP);
    end
    check("t6_ovf", ovf, 1'b0);
    check_line("t6");
    wait_idle("t6", 50);
    clear_rx();

    // Default baud rate: start bit width and whole-packet duration
    p = cyc;
    valid_s = 1'b1; x_s = 16'h1234; y_s = 16'hABCD; exc_s = 1'b1;
    @(negedge clk);
    valid_s = 1'b0;
    w = 0;
    while (tx_s !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("t5_start_cycle", cyc, p + 2);
    w = 0;
    while (tx_s === 1'b0 && w < 2000) begin
      w++;
      @(negedge clk);
    end
    check("t5_start_width", w, 434);
    while (busy_s && cyc < p + 30000) @(negedge clk);
    check("t5_packet_end", cyc, p + 2 + 21700);
    check("t5_tx_idle", tx_s, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gpu_result_uart_tx.md
# gpu_result_uart_tx

Result-reporting transmitter: accepts projected vertex results (X, Y, exception flag) from the graphics pipeline, buffers them in a small FIFO, and serializes each as a 5-byte packet on the UART TX line back to the host. It is the outbound counterpart of the memory manager's UART receive path and drives the top-level oTx pin.

## Interface
- CLKS_PER_BIT, default 434 — iClock cycles per UART bit (50 MHz / 115200); legal ≥ 2.
- FIFO_DEPTH, default 4 — result entries buffered; power of two, ≥ 2.

- iClock  input  1  system clock, all logic on rising edge.
- iReset  input  1  reset, asynchronous, active-low.
- iValid  input  1  result strobe; one result accepted per cycle when iValid=1 and oReady=1.
- iX  input  16  projected X (o_X of pipeline), two's complement, passed through unmodified.
- iY  input  16  projected Y.
- iException  input  1  pipeline exception flag for this result.
- oReady  output  1  FIFO count < FIFO_DEPTH (registered count).
- oTx  output  1  UART serial line, idle high.
- oBusy  output  1  FSM not IDLE or FIFO non-empty.
- oOverflow  output  1  sticky: a result was offered with iValid=1 while oReady=0.

## Operation
- Packet per result, 5 bytes in order: header {7'b1010010, exception} (0xA4 or 0xA5), X[15:8], X[7:0], Y[15:8], Y[7:0].
- Frame per byte: start bit 0, 8 data bits LSB first, stop bit 1; 10 bits, no parity.
- FIFO: 33-bit entries {exception, X, Y}; push when iValid && oReady. Offer while full is dropped and sets oOverflow, even if a pop occurs the same cycle. Simultaneous push and pop with count < FIFO_DEPTH: count unchanged, both take effect.
- FSM states:
  - IDLE: oTx=1. If FIFO non-empty: pop head into a 40-bit packet shift register, byte index := 0, go to START.
  - START: oTx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: oTx=current byte bit[bit index] for CLKS_PER_BIT cycles each. After bit 7 go to STOP.
  - STOP: oTx=1 for CLKS_PER_BIT cycles. If byte index < 4: increment it and go to START with no gap. Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state or bit change; width is clog2(CLKS_PER_BIT).
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Reset values: oTx=1, oReady=1, oBusy=0, oOverflow=0, FIFO empty, FSM IDLE, all counters 0.
- Reset asserted mid-frame: oTx goes high immediately (asynchronous). The partial frame is abandoned and FIFO contents are discarded. After release, transmission resumes only on new pushes.
- oOverflow clears only on reset.

## Timing
- Push at cycle 0: count=1 at cycle 1; IDLE pops at cycle 1; oTx falls at cycle 2.
- Packet length on the line: 50·CLKS_PER_BIT cycles. Adjacent bytes in a packet are contiguous.
- Between packets: exactly one IDLE cycle with oTx=1 (the pop cycle) after the last stop bit, then the next start bit.
- oReady reflects the registered count. It deasserts the cycle after the push that fills the FIFO, and reasserts the cycle after a pop from full.
- oBusy falls in the cycle the FSM enters IDLE with the FIFO empty.
- oOverflow rises the cycle after the dropped offer.

## Test plan
- CLKS_PER_BIT=4, one push X=0x1234, Y=0xABCD, exc=0 at cycle 0 -> oTx low at cycle 2; decoded bytes A4 12 34 AB CD; oBusy deasserts at cycle 202; oTx stays high afterward.
- Push X=0xFFFF, Y=0x8000, exc=1 -> bytes A5 FF FF 80 00; each bit held exactly 4 cycles; stop bits high.
- FIFO_DEPTH=4, six consecutive pushes (cycles 0–5) with distinct X values 1..6 -> oReady=0 from cycle 5; 6th result dropped; oOverflow=1 at cycle 6 and sticky; results 1–5 transmitted in order; one idle-high cycle between packets.
- Reset asserted during DATA of byte 2 with 2 entries queued -> oTx=1 asynchronously; after release oBusy=0, oReady=1, oOverflow=0; no further line activity until a new push.
- Default CLKS_PER_BIT=434, one push -> measured start-bit width 434 cycles; full packet 21700 cycles.
- Push coincident with the pop of a queued entry at count=2 -> count remains 2, oReady stays 1, and all results are sent in order with none lost.
